// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and types for the round-robin packet arbiter
package arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int DATA_W  = 8;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/rr_arb_pipe_if.sv
// rtl/rr_arb_pipe_if.sv - requester/downstream bundle of the round-robin packet arbiter
interface rr_arb_pipe_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0]        in_valid;
  logic [NUM_REQ-1:0]        in_last;
  logic [NUM_REQ*DATA_W-1:0] in_data;
  logic [NUM_REQ-1:0]        out_stall;
  logic                      in_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  idx_t                      out_src;
  logic                      out_last;

  modport master (
    output in_valid, in_last, in_data, in_ready,
    input  out_stall, out_valid, out_data, out_src, out_last
  );

  modport slave (
    input  in_valid, in_last, in_data, in_ready,
    output out_stall, out_valid, out_data, out_src, out_last
  );
endinterface

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin pick over four requesters
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  idx_t               last_idx,
  output logic               grant_valid,
  output idx_t               grant_idx
);

  idx_t cand;

  // Walk offsets from farthest to nearest so the nearest requester after last_idx wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = last_idx;
    cand        = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = last_idx + idx_t'(k);
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arb_pipe.sv
// rtl/rr_arb_pipe.sv - four-way round-robin packet arbiter with a single output register
module rr_arb_pipe
  import arb_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  rr_arb_pipe_if.slave bus
);

  logic [0:0] state;
  idx_t       lock_idx;
  idx_t       last_grant;

  logic       pick_valid;
  idx_t       pick_idx;
  logic       grant_valid;
  idx_t       grant_idx;
  logic       take;
  logic       accept;
  logic       grant_last;

  rr_pick4 u_pick (
    .req         (bus.in_valid),
    .last_idx    (last_grant),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  // A locked owner with no valid beat produces a bubble rather than releasing the lock.
  always_comb begin
    if (state == ST_LOCKED) begin
      grant_valid = bus.in_valid[lock_idx];
      grant_idx   = lock_idx;
    end else begin
      grant_valid = pick_valid;
      grant_idx   = pick_idx;
    end
  end

  assign take       = !bus.out_valid || bus.in_ready;
  assign accept     = take && grant_valid;
  assign grant_last = bus.in_last[grant_idx];

  assign bus.out_stall = bus.in_valid &
                         ~(accept ? (NUM_REQ'(1) << grant_idx) : NUM_REQ'(0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
      bus.out_last  <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data[int'(grant_idx)*DATA_W +: DATA_W];
      bus.out_src   <= grant_idx;
      bus.out_last  <= grant_last;
    end else if (bus.in_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      lock_idx   <= '0;
      last_grant <= idx_t'(NUM_REQ - 1);
    end else if (accept) begin
      if (state == ST_IDLE) begin
        last_grant <= grant_idx;
        if (!grant_last) begin
          state    <= ST_LOCKED;
          lock_idx <= grant_idx;
        end
      end else if (grant_last) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_pipe.sv
// tb/tb_rr_arb_pipe.sv - scoreboard bench for the round-robin packet arbiter
module tb_rr_arb_pipe;
  import arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rr_arb_pipe_if bus ();

  rr_arb_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] src;
    logic       last;
  } beat_t;

  beat_t      exp_q[$];
  beat_t      mon_e;
  int         vectors = 0;
  int         miscompares = 0;

  int         owner;
  int         lg;
  logic       m_ov;
  logic       hold[4];
  logic       h_last[4];
  logic [7:0] h_data[4];
  logic [3:0] cur_v;
  logic [3:0] cur_l;
  logic [31:0] cur_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    lg    = 3;
    m_ov  = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      hold[i]   = 1'b0;
      h_last[i] = 1'b0;
      h_data[i] = '0;
    end
  endtask

  // Stalled requesters keep their beat; the others take the offered values with fresh data.
  task automatic drive_cycle(input logic [3:0] v, input logic [3:0] l, input logic rdy);
    int         g;
    int         idx;
    logic       take;
    logic       acc;
    logic [3:0] exp_stall;
    for (int i = 0; i < 4; i++) begin
      if (hold[i]) begin
        cur_v[i]        = 1'b1;
        cur_l[i]        = h_last[i];
        cur_d[i*8 +: 8] = h_data[i];
      end else begin
        cur_v[i]        = v[i];
        cur_l[i]        = l[i];
        cur_d[i*8 +: 8] = 8'($urandom);
      end
    end
    bus.in_valid = cur_v;
    bus.in_last  = cur_l;
    bus.in_data  = cur_d;
    bus.in_ready = rdy;
    #1;
    take = !m_ov || rdy;
    g = -1;
    if (owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        idx = (lg + k) % 4;
        if (g < 0 && cur_v[idx]) g = idx;
      end
    end else if (cur_v[owner]) begin
      g = owner;
    end
    acc = take && (g >= 0);
    exp_stall = cur_v;
    if (acc) exp_stall[g] = 1'b0;
    check("out_stall", 32'(bus.out_stall), 32'(exp_stall));
    check("out_valid", 32'(bus.out_valid), 32'(m_ov));
    if (acc) begin
      exp_q.push_back({cur_d[g*8 +: 8], 2'(g), cur_l[g]});
      if (owner < 0) begin
        lg = g;
        if (!cur_l[g]) owner = g;
      end else if (cur_l[g]) begin
        owner = -1;
      end
    end
    m_ov = acc ? 1'b1 : (rdy ? 1'b0 : m_ov);
    for (int i = 0; i < 4; i++) begin
      hold[i]   = cur_v[i] && exp_stall[i];
      h_last[i] = cur_l[i];
      h_data[i] = cur_d[i*8 +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = '0;
    bus.in_last  = '0;
    bus.in_data  = '0;
    bus.in_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.in_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", 32'(bus.out_data), 32'(mon_e.data));
        check("out_src",  32'(bus.out_src),  32'(mon_e.src));
        check("out_last", 32'(bus.out_last), 32'(mon_e.last));
      end
    end
  end

  function automatic logic any_hold();
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) r = r | hold[i];
    return r;
  endfunction

  initial begin
    reset        = 1'b1;
    bus.in_valid = '0;
    bus.in_last  = '0;
    bus.in_data  = '0;
    bus.in_ready = 1'b1;
    model_reset();
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_src",   32'(bus.out_src),   32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    bus.in_valid = 4'b1111;
    #1;
    check("rst_out_stall", 32'(bus.out_stall), 32'(4'b1110));
    bus.in_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // full round-robin rotation of single-beat packets
    repeat (5) drive_cycle(4'b1111, 4'b1111, 1'b1);
    repeat (3) drive_cycle(4'b0000, 4'b0000, 1'b1);

    // three-beat packet from requester 2 against a persistent requester 0
    do_reset();
    drive_cycle(4'b0100, 4'b0000, 1'b1);
    drive_cycle(4'b0101, 4'b0001, 1'b1);
    drive_cycle(4'b0101, 4'b0101, 1'b1);
    drive_cycle(4'b0001, 4'b0001, 1'b1);
    repeat (3) drive_cycle(4'b0000, 4'b0000, 1'b1);

    // downstream backpressure with two requesters waiting
    drive_cycle(4'b0011, 4'b0011, 1'b1);
    repeat (4) drive_cycle(4'b0011, 4'b0011, 1'b0);
    repeat (4) drive_cycle(4'b0000, 4'b0000, 1'b1);

    // locked owner bubbles while another requester waits
    drive_cycle(4'b0010, 4'b0000, 1'b1);
    repeat (2) drive_cycle(4'b1000, 4'b0000, 1'b1);
    drive_cycle(4'b1010, 4'b1010, 1'b1);
    repeat (3) drive_cycle(4'b0000, 4'b0000, 1'b1);

    // reset while locked on requester 2 with a held beat
    drive_cycle(4'b0100, 4'b0000, 1'b1);
    drive_cycle(4'b0100, 4'b0000, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    model_reset();
    bus.in_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_cycle(4'b0100, 4'b0100, 1'b1);
    check("post_rst_src", 32'(bus.out_src), 32'd2);
    repeat (2) drive_cycle(4'b0000, 4'b0000, 1'b1);

    // wrap-around from last_grant=3 to requester 0
    do_reset();
    drive_cycle(4'b0001, 4'b0001, 1'b1);
    check("wrap_src",   32'(bus.out_src),   32'd0);
    check("wrap_valid", 32'(bus.out_valid), 32'd1);
    repeat (2) drive_cycle(4'b0000, 4'b0000, 1'b1);

    repeat (3000) begin
      drive_cycle(4'($urandom) & 4'($urandom | $urandom), 4'($urandom), ($urandom % 4) != 0);
    end

    for (int n = 0; n < 40; n++) begin
      if (exp_q.size() != 0 || any_hold()) drive_cycle(4'b0000, 4'b0000, 1'b1);
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
